// File: rtl/alu_cmp_pkg.sv
// Shared types and constants for the serial nibble comparator.
package alu_cmp_pkg;

    // Default operand size, in 4-bit nibbles, and the resulting operand width.
    localparam int NIBBLES_DEF = 8;
    localparam int OP_W        = 4 * NIBBLES_DEF;

    // Controller states: waiting for operands, stepping nibbles, holding a result.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } cmp_state_t;

    // Width of a nibble index for n nibbles (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_cmp.sv
// Unsigned magnitude compare of one nibble pair; purely combinational.
module nibble_cmp (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       gt,
    output logic       lt
);

    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/serial_compare_32.sv
// Serial magnitude comparator: walks the operands one nibble per cycle from
// the most significant end and stops at the first differing nibble.
// Optional build macro CMP_SIGNED_EN enables two's-complement ordering when
// signed_op is captured high; without it signed_op is accepted but ignored.
module serial_compare_32
    import alu_cmp_pkg::*;
#(
    parameter int NIBBLES = NIBBLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 signed_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 gt,
    output logic                 lt,
    output logic                 eq,
    output logic                 busy
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NIBBLES - 1);

    cmp_state_t       r_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic             r_signed;
    logic [IDX_W-1:0] r_idx;
    logic             r_gt;
    logic             r_lt;
    logic             r_eq;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             r_busy;

    logic             w_flip;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic             w_gt;
    logic             w_lt;

`ifdef CMP_SIGNED_EN
    // Flipping the sign bit of both operands on the top nibble turns
    // two's-complement order into plain unsigned order.
    assign w_flip = r_signed && (r_idx == IDX_TOP);
`else
    logic w_unused_signed;
    assign w_flip          = 1'b0;
    assign w_unused_signed = r_signed;
`endif

    assign w_a_nib = r_a[{r_idx, 2'b00} +: 4] ^ {w_flip, 3'b000};
    assign w_b_nib = r_b[{r_idx, 2'b00} +: 4] ^ {w_flip, 3'b000};

    nibble_cmp u_nibble_cmp (
        .a  (w_a_nib),
        .b  (w_b_nib),
        .gt (w_gt),
        .lt (w_lt)
    );

    // Controller: capture, serial compare with early exit, result hold.
    // NOTE: every register here, operands included, takes a defined reset
    // value and is updated with <= so all of them see the same pre-edge state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_signed    <= 1'b0;
            r_idx       <= '0;
            r_gt        <= 1'b0;
            r_lt        <= 1'b0;
            r_eq        <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_signed   <= signed_op;
                        r_idx      <= IDX_TOP;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_gt || w_lt) begin
                        r_gt        <= w_gt;
                        r_lt        <= w_lt;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_DONE;
                    end else if (r_idx == '0) begin
                        r_eq        <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_gt        <= 1'b0;
                        r_lt        <= 1'b0;
                        r_eq        <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_gt        <= 1'b0;
                    r_lt        <= 1'b0;
                    r_eq        <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign gt        = r_gt;
    assign lt        = r_lt;
    assign eq        = r_eq;

endmodule

// File: tb/tb_serial_compare_32.sv
// Self-checking bench for serial_compare_32: directed corner cases plus
// randomized operand pairs against an arithmetic reference model.
// Honours CMP_SIGNED_EN the same way as the design build.
module tb_serial_compare_32;

`ifdef CMP_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        signed_op = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        gt;
    logic        lt;
    logic        eq;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Expected flags of the transaction currently in flight.
    logic exp_gt = 1'b0;
    logic exp_lt = 1'b0;
    logic exp_eq = 1'b0;

    serial_compare_32 #(.NIBBLES(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .signed_op (signed_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gt        (gt),
        .lt        (lt),
        .eq        (eq),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: ordinary integer compare, latency from leading equal nibbles.
    function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic s,
                                  output logic g, output logic l, output logic e,
                                  output int lat);
        logic use_signed;
        use_signed = s & SIGNED_EN;
        if (use_signed) begin
            g = ($signed(x) > $signed(y));
            l = ($signed(x) < $signed(y));
        end else begin
            g = (x > y);
            l = (x < y);
        end
        e = (x == y);
        lat = 1;
        for (int i = 7; i > 0; i--) begin
            if (x[4*i +: 4] != y[4*i +: 4]) break;
            lat++;
        end
    endfunction

    // Every cycle: exactly one of in_ready/busy/out_valid, and flags that
    // match the current expectation while valid and are zero otherwise.
    always @(negedge clk) begin
        check("one_phase", 32'(in_ready) + 32'(busy) + 32'(out_valid), 32'd1);
        if (out_valid)
            check("flags_valid", 32'({gt, lt, eq}), 32'({exp_gt, exp_lt, exp_eq}));
        else
            check("flags_idle", 32'({gt, lt, eq}), 32'd0);
    end

    task automatic run_txn(input logic [31:0] x, input logic [31:0] y, input logic s,
                           input int hold, input logic pre_ready);
        logic g, l, e;
        int   lat;
        int   cyc;
        int   w;
        model(x, y, s, g, l, e, lat);
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        exp_gt    = g;
        exp_lt    = l;
        exp_eq    = e;
        a         = x;
        b         = y;
        signed_op = s;
        in_valid  = 1'b1;
        out_ready = pre_ready;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        a         = $urandom;
        b         = $urandom;
        signed_op = 1'($urandom % 2);
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end while (!out_valid && cyc < 20);
        check("latency", 32'(cyc), 32'(lat));
        check("out_valid_up", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom % 2);
            a        = $urandom;
            b        = $urandom;
            @(posedge clk);
            @(negedge clk);
            check("in_ready_done", 32'(in_ready), 32'd0);
            check("out_valid_hold", 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("idle_after_hs", 32'(in_ready), 32'd1);
        check("out_valid_drop", 32'(out_valid), 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic g, l, e;
        int   lat;
        logic [31:0] x, y;

        // Pin the reference model against hand-computed results.
        model(32'hF000_0000, 32'h0FFF_FFFF, 1'b0, g, l, e, lat);
        check("model_gt_first", 32'({g, l, e, 8'(lat)}), {21'd0, 3'b100, 8'd1});
        model(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, g, l, e, lat);
        check("model_gt_last", 32'({g, l, e, 8'(lat)}), {21'd0, 3'b100, 8'd8});
        model(32'h0000_0000, 32'h0000_000F, 1'b0, g, l, e, lat);
        check("model_lt_last", 32'({g, l, e, 8'(lat)}), {21'd0, 3'b010, 8'd8});
        model(32'h1234_5678, 32'h1234_5678, 1'b0, g, l, e, lat);
        check("model_eq", 32'({g, l, e, 8'(lat)}), {21'd0, 3'b001, 8'd8});
        model(32'h8000_0000, 32'h0000_0001, 1'b1, g, l, e, lat);
        check("model_signed", 32'({g, l, e, 8'(lat)}),
              SIGNED_EN ? {21'd0, 3'b010, 8'd1} : {21'd0, 3'b100, 8'd1});

        // Reset state.
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_flags", 32'({gt, lt, eq}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corners.
        run_txn(32'hF000_0000, 32'h0FFF_FFFF, 1'b0, 0, 1'b0);
        run_txn(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 0, 1'b1);
        run_txn(32'h0000_0000, 32'h0000_000F, 1'b0, 1, 1'b0);
        run_txn(32'h1234_5678, 32'h1234_5678, 1'b0, 5, 1'b0);
        run_txn(32'h8000_0000, 32'h0000_0001, 1'b1, 2, 1'b0);
        run_txn(32'h8000_0000, 32'h0000_0001, 1'b0, 0, 1'b0);
        run_txn(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 0, 1'b1);

        // Reset pulse while RUN sits at nibble index 4.
        @(negedge clk);
        exp_gt    = 1'b0;
        exp_lt    = 1'b1;
        exp_eq    = 1'b0;
        a         = 32'h1234_0000;
        b         = 32'h1234_5678;
        signed_op = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("busy_before_rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(32'h1234_5678, 32'h1234_0000, 1'b0, 0, 1'b0);

        // Randomized pairs, biased towards long runs of equal leading nibbles.
        for (int n = 0; n < 150; n++) begin
            x = $urandom;
            case ($urandom % 3)
                0:       y = $urandom;
                1:       y = x ^ ($urandom >> ($urandom % 33));
                default: y = x;
            endcase
            run_txn(x, y, 1'($urandom % 2), int'($urandom % 3), 1'($urandom % 2));
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
